// File: rtl/cm0ik_ahb_pkg.sv
// Shared types for the Cortex-M0 kit AHB decoder/mux: slave indices,
// default-slave states, HTRANS encodings and an inclusive range helper.
package cm0ik_ahb_pkg;

  typedef enum logic [1:0] {
    SLV_ROM = 2'd0,
    SLV_RAM = 2'd1,
    SLV_APB = 2'd2,
    SLV_DEF = 2'd3
  } slv_e;

  typedef enum logic [1:0] {
    DS_IDLE = 2'd0,
    DS_ERR1 = 2'd1,
    DS_ERR2 = 2'd2
  } ds_state_e;

  localparam logic [1:0] HTRANS_IDLE   = 2'b00;
  localparam logic [1:0] HTRANS_BUSY   = 2'b01;
  localparam logic [1:0] HTRANS_NONSEQ = 2'b10;
  localparam logic [1:0] HTRANS_SEQ    = 2'b11;

  // Inclusive region match; bounds are passed as arguments so a zero base
  // does not turn the lower comparison into a constant expression.
  function automatic logic addr_in_range(input logic [31:0] addr,
                                         input logic [31:0] base,
                                         input logic [31:0] top);
    return (addr >= base) && (addr <= top);
  endfunction

endpackage

// File: rtl/cm0ik_ahb_default_slave.sv
// Default slave for unmapped AHB accesses: two-cycle ERROR response FSM
// and a saturating count of ERROR responses issued.
module cm0ik_ahb_default_slave
  import cm0ik_ahb_pkg::*;
(
  input  logic       HCLK,
  input  logic       HRESET,
  input  logic       HREADY,
  input  logic       def_sel,
  input  logic [1:0] HTRANS,
  output logic       def_hready,
  output logic       def_hresp,
  output logic [7:0] ERRCNT
);

  ds_state_e  state;
  logic       rdy_q;
  logic       resp_q;
  logic [7:0] errcnt_q;
  logic       accept;
  logic       unused_htrans0;

  // Only NONSEQ/SEQ (HTRANS[1]) start an ERROR; IDLE/BUSY get zero-wait OKAY.
  assign accept         = HREADY & def_sel & HTRANS[1];
  assign unused_htrans0 = HTRANS[0];

  function automatic logic [7:0] sat_inc(input logic [7:0] v);
    return (v == 8'hFF) ? v : v + 8'd1;
  endfunction

  // ERROR sequencer with registered HREADY/HRESP and the error counter.
  always_ff @(posedge HCLK) begin
    if (HRESET) begin
      state    <= DS_IDLE;
      rdy_q    <= 1'b1;
      resp_q   <= 1'b0;
      errcnt_q <= 8'd0;
    end else begin
      case (state)
        DS_IDLE: begin
          if (accept) begin
            state    <= DS_ERR1;
            rdy_q    <= 1'b0;
            resp_q   <= 1'b1;
            errcnt_q <= sat_inc(errcnt_q);
          end
        end
        DS_ERR1: begin
          state  <= DS_ERR2;
          rdy_q  <= 1'b1;
          resp_q <= 1'b1;
        end
        DS_ERR2: begin
          if (accept) begin
            state    <= DS_ERR1;
            rdy_q    <= 1'b0;
            resp_q   <= 1'b1;
            errcnt_q <= sat_inc(errcnt_q);
          end else begin
            state  <= DS_IDLE;
            rdy_q  <= 1'b1;
            resp_q <= 1'b0;
          end
        end
        default: begin
          state  <= DS_IDLE;
          rdy_q  <= 1'b1;
          resp_q <= 1'b0;
        end
      endcase
    end
  end

  assign def_hready = rdy_q;
  assign def_hresp  = resp_q;
  assign ERRCNT     = errcnt_q;

endmodule

// File: rtl/cm0ik_ahb_decmux.sv
// AHB-Lite address decoder, response mux and default slave for the
// Cortex-M0 kit MCU (ROM, RAM, APB bridge).
// Optional feature macro: CM0IK_ROM_WRITE_ERR_EN -- when defined, writes
// to the ROM region are decoded to the default slave and receive ERROR.
module cm0ik_ahb_decmux
  import cm0ik_ahb_pkg::*;
#(
  parameter logic [31:0] ROMBASE = 32'h00000000,
  parameter logic [31:0] ROMTOP  = 32'h0003FFFF,
  parameter logic [31:0] RAMBASE = 32'h20000000,
  parameter logic [31:0] RAMTOP  = 32'h2000FFFF,
  parameter logic [31:0] APBBASE = 32'h40000000,
  parameter logic [31:0] APBTOP  = 32'h4000FFFF
) (
  input  logic        HCLK,
  input  logic        HRESET,
  input  logic [31:0] HADDR,
  input  logic [1:0]  HTRANS,
  input  logic        HWRITE,
  output logic [31:0] HRDATA,
  output logic        HREADY,
  output logic        HRESP,
  output logic        HSELROM,
  output logic        HSELRAM,
  output logic        HSELAPB,
  input  logic [31:0] HRDATAROM,
  input  logic [31:0] HRDATARAM,
  input  logic [31:0] HRDATAAPB,
  input  logic        HREADYOUTROM,
  input  logic        HREADYOUTRAM,
  input  logic        HREADYOUTAPB,
  input  logic        HRESPROM,
  input  logic        HRESPRAM,
  input  logic        HRESPAPB,
  output logic [7:0]  ERRCNT
);

  logic rom_hit;
  logic ram_hit;
  logic apb_hit;
  logic rom_wr_err;
  slv_e asel;
  slv_e dsel;
  logic def_hready;
  logic def_hresp;

  assign rom_hit = addr_in_range(HADDR, ROMBASE, ROMTOP);
  assign ram_hit = addr_in_range(HADDR, RAMBASE, RAMTOP);
  assign apb_hit = addr_in_range(HADDR, APBBASE, APBTOP);

`ifdef CM0IK_ROM_WRITE_ERR_EN
  assign rom_wr_err = rom_hit & HWRITE & HTRANS[1];
`else
  logic unused_hwrite;
  assign unused_hwrite = HWRITE;
  assign rom_wr_err    = 1'b0;
`endif

  // Address-phase decode with ROM > RAM > APB priority; misses go to DEF.
  always_comb begin
    asel = SLV_DEF;
    if (rom_hit && !rom_wr_err) asel = SLV_ROM;
    else if (rom_hit)           asel = SLV_DEF;
    else if (ram_hit)           asel = SLV_RAM;
    else if (apb_hit)           asel = SLV_APB;
  end

  assign HSELROM = (asel == SLV_ROM);
  assign HSELRAM = (asel == SLV_RAM);
  assign HSELAPB = (asel == SLV_APB);

  // Data-phase select follows the accepted address phase; frozen by waits.
  always_ff @(posedge HCLK) begin
    if (HRESET)      dsel <= SLV_DEF;
    else if (HREADY) dsel <= asel;
  end

  // Data-phase response mux toward the master.
  always_comb begin
    HRDATA = 32'd0;
    HREADY = def_hready;
    HRESP  = def_hresp;
    case (dsel)
      SLV_ROM: begin
        HRDATA = HRDATAROM;
        HREADY = HREADYOUTROM;
        HRESP  = HRESPROM;
      end
      SLV_RAM: begin
        HRDATA = HRDATARAM;
        HREADY = HREADYOUTRAM;
        HRESP  = HRESPRAM;
      end
      SLV_APB: begin
        HRDATA = HRDATAAPB;
        HREADY = HREADYOUTAPB;
        HRESP  = HRESPAPB;
      end
      default: begin
        HRDATA = 32'd0;
        HREADY = def_hready;
        HRESP  = def_hresp;
      end
    endcase
  end

  cm0ik_ahb_default_slave u_default_slave (
    .HCLK       (HCLK),
    .HRESET     (HRESET),
    .HREADY     (HREADY),
    .def_sel    (asel == SLV_DEF),
    .HTRANS     (HTRANS),
    .def_hready (def_hready),
    .def_hresp  (def_hresp),
    .ERRCNT     (ERRCNT)
  );

endmodule

// File: tb/tb_cm0ik_ahb_decmux.sv
// Directed bench for cm0ik_ahb_decmux: per-cycle vector table plus
// hand-written sequences for saturation and reset corner cases.
module tb_cm0ik_ahb_decmux;

  localparam logic [31:0] D_ROM = 32'hDEADBEEF;
  localparam logic [31:0] D_RAM = 32'h12345678;
  localparam logic [31:0] D_APB = 32'hCAFEF00D;
`ifdef CM0IK_ROM_WRITE_ERR_EN
  localparam bit WERR = 1'b1;
`else
  localparam bit WERR = 1'b0;
`endif

  logic        HCLK = 1'b0;
  logic        HRESET;
  logic [31:0] HADDR;
  logic [1:0]  HTRANS;
  logic        HWRITE;
  logic [31:0] HRDATA;
  logic        HREADY, HRESP, HSELROM, HSELRAM, HSELAPB;
  logic        HREADYOUTRAM;
  logic        HRESPAPB;
  logic [7:0]  ERRCNT;

  int checks   = 0;
  int failures = 0;

  always #5 HCLK = ~HCLK;

  cm0ik_ahb_decmux dut (
    .HCLK(HCLK), .HRESET(HRESET), .HADDR(HADDR), .HTRANS(HTRANS), .HWRITE(HWRITE),
    .HRDATA(HRDATA), .HREADY(HREADY), .HRESP(HRESP),
    .HSELROM(HSELROM), .HSELRAM(HSELRAM), .HSELAPB(HSELAPB),
    .HRDATAROM(D_ROM), .HRDATARAM(D_RAM), .HRDATAAPB(D_APB),
    .HREADYOUTROM(1'b1), .HREADYOUTRAM(HREADYOUTRAM), .HREADYOUTAPB(1'b1),
    .HRESPROM(1'b0), .HRESPRAM(1'b0), .HRESPAPB(HRESPAPB),
    .ERRCNT(ERRCNT)
  );

  typedef struct {
    logic [31:0] addr;
    logic [1:0]  trans;
    logic        wr;
    logic        rdyram;
    logic        respapb;
    logic        selrom, selram, selapb;
    logic        rdy, resp;
    logic [31:0] rdata;
    logic [7:0]  errcnt;
  } vec_t;

  typedef struct {
    logic [31:0] addr;
    logic        selrom, selram, selapb;
  } dec_t;

  vec_t vecs[17];
  dec_t decs[8];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge HCLK);
    #1;
  endtask

  task automatic drive(input logic [31:0] a, input logic [1:0] t, input logic w);
    HADDR  = a;
    HTRANS = t;
    HWRITE = w;
  endtask

  initial begin
    // addr, trans, wr, rdyram, respapb | selrom, selram, selapb, rdy, resp, rdata, errcnt
    vecs[0]  = '{32'h00000010, 2'b10, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 32'h0, 8'd0};
    vecs[1]  = '{32'h20000000, 2'b10, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0, D_ROM, 8'd0};
    vecs[2]  = '{32'h40000000, 2'b10, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, D_RAM, 8'd0};
    vecs[3]  = '{32'h40000000, 2'b10, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, D_RAM, 8'd0};
    vecs[4]  = '{32'h40000000, 2'b10, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, D_RAM, 8'd0};
    vecs[5]  = '{32'h80000000, 2'b10, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, D_APB, 8'd0};
    vecs[6]  = '{32'h80000004, 2'b00, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 32'h0, 8'd1};
    vecs[7]  = '{32'h80000000, 2'b00, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 32'h0, 8'd1};
    vecs[8]  = '{32'h80000000, 2'b00, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 32'h0, 8'd1};
    vecs[9]  = '{32'h80000000, 2'b10, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 32'h0, 8'd1};
    vecs[10] = '{32'h90000000, 2'b10, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 32'h0, 8'd2};
    vecs[11] = '{32'h90000000, 2'b10, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 32'h0, 8'd2};
    vecs[12] = '{32'h00000004, 2'b10, 1'b1, 1'b1, 1'b0, !WERR, 1'b0, 1'b0, 1'b0, 1'b1, 32'h0, 8'd3};
    vecs[13] = '{32'h00000004, 2'b10, 1'b1, 1'b1, 1'b0, !WERR, 1'b0, 1'b0, 1'b1, 1'b1, 32'h0, 8'd3};
    vecs[14] = '{32'h20000000, 2'b00, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0, !WERR, WERR,
                 WERR ? 32'h0 : D_ROM, WERR ? 8'd4 : 8'd3};
    vecs[15] = '{32'h20000000, 2'b00, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1, WERR,
                 WERR ? 32'h0 : D_RAM, WERR ? 8'd4 : 8'd3};
    vecs[16] = '{32'h20000000, 2'b00, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0,
                 D_RAM, WERR ? 8'd4 : 8'd3};

    decs[0] = '{32'h0003FFFF, 1'b1, 1'b0, 1'b0};
    decs[1] = '{32'h00040000, 1'b0, 1'b0, 1'b0};
    decs[2] = '{32'h1FFFFFFF, 1'b0, 1'b0, 1'b0};
    decs[3] = '{32'h2000FFFF, 1'b0, 1'b1, 1'b0};
    decs[4] = '{32'h20010000, 1'b0, 1'b0, 1'b0};
    decs[5] = '{32'h3FFFFFFF, 1'b0, 1'b0, 1'b0};
    decs[6] = '{32'h4000FFFF, 1'b0, 1'b0, 1'b1};
    decs[7] = '{32'h40010000, 1'b0, 1'b0, 1'b0};

    HRESET = 1'b1;
    HREADYOUTRAM = 1'b1;
    HRESPAPB = 1'b0;
    drive(32'h20000000, 2'b00, 1'b0);
    #1;
    chk("hsel_during_reset", {29'd0, HSELROM, HSELRAM, HSELAPB}, 32'b010);
    tick();
    tick();
    HRESET = 1'b0;
    #1;
    chk("rst_hready", HREADY, 1'b1);
    chk("rst_hresp", HRESP, 1'b0);
    chk("rst_hrdata", HRDATA, 32'h0);
    chk("rst_errcnt", ERRCNT, 8'd0);

    // Region boundaries with IDLE transfers (no state change).
    for (int i = 0; i < 8; i++) begin
      drive(decs[i].addr, 2'b00, 1'b0);
      #1;
      chk($sformatf("dec%0d_sel", i), {29'd0, HSELROM, HSELRAM, HSELAPB},
          {29'd0, decs[i].selrom, decs[i].selram, decs[i].selapb});
    end
    tick();

    // Cycle-by-cycle vector table.
    for (int i = 0; i < 17; i++) begin
      drive(vecs[i].addr, vecs[i].trans, vecs[i].wr);
      HREADYOUTRAM = vecs[i].rdyram;
      HRESPAPB     = vecs[i].respapb;
      #1;
      chk($sformatf("v%0d_hsel", i), {29'd0, HSELROM, HSELRAM, HSELAPB},
          {29'd0, vecs[i].selrom, vecs[i].selram, vecs[i].selapb});
      chk($sformatf("v%0d_hready", i), HREADY, vecs[i].rdy);
      chk($sformatf("v%0d_hresp", i), HRESP, vecs[i].resp);
      chk($sformatf("v%0d_hrdata", i), HRDATA, vecs[i].rdata);
      chk($sformatf("v%0d_errcnt", i), ERRCNT, vecs[i].errcnt);
      tick();
    end
    HREADYOUTRAM = 1'b1;
    HRESPAPB = 1'b0;

    // 300 back-to-back unmapped NONSEQ transfers: 600 edges leave the FSM in ERR2.
    drive(32'h80000000, 2'b10, 1'b0);
    for (int i = 0; i < 600; i++) tick();
    chk("sat_err2_hready", HREADY, 1'b1);
    chk("sat_err2_hresp", HRESP, 1'b1);
    chk("sat_errcnt", ERRCNT, 8'hFF);
    tick();
    chk("sat_err1_hready", HREADY, 1'b0);
    chk("sat_err1_hresp", HRESP, 1'b1);
    chk("sat_errcnt_hold", ERRCNT, 8'hFF);

    // Reset in ERR1 aborts the ERROR on the next edge.
    HRESET = 1'b1;
    tick();
    HRESET = 1'b0;
    drive(32'h80000000, 2'b00, 1'b0);
    #1;
    chk("rst_err1_hready", HREADY, 1'b1);
    chk("rst_err1_hresp", HRESP, 1'b0);
    chk("rst_err1_errcnt", ERRCNT, 8'd0);
    chk("rst_err1_hrdata", HRDATA, 32'h0);

    // Reset during a RAM wait abandons the wait (dsel back to DEF).
    drive(32'h20000004, 2'b10, 1'b0);
    tick();
    drive(32'h20000008, 2'b00, 1'b0);
    HREADYOUTRAM = 1'b0;
    #1;
    chk("ramwait_hready", HREADY, 1'b0);
    chk("ramwait_hrdata", HRDATA, D_RAM);
    HRESET = 1'b1;
    tick();
    HRESET = 1'b0;
    #1;
    chk("rst_ramwait_hready", HREADY, 1'b1);
    chk("rst_ramwait_hrdata", HRDATA, 32'h0);
    chk("rst_ramwait_hresp", HRESP, 1'b0);
    tick();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
